// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings and constants for the writeback stage
package wb_pkg;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK, WB_BAD} wb_sel_e;
    typedef enum logic [1:0] {LD_B, LD_H, LD_W} ld_size_e;
    localparam int LINK_INC = 2;
endpackage

// File: rtl/writeback_stage_load_extend.sv
// load_extend: picks the addressed byte/half lane of a memory word and sign- or zero-extends it
module load_extend
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            mem_data,
    input  logic [1:0]                   ld_size,
    input  logic                         ld_signed,
    input  logic [$clog2(DATA_W/8)-1:0]  byte_off,
    output logic [DATA_W-1:0]            ext
);
    localparam int IDX_W = $clog2(DATA_W / 8) + 3;
    logic [IDX_W-1:0] b_idx, h_idx;
    logic [7:0]       b_val;
    logic [15:0]      h_val;
    // Half lanes are aligned by clearing the low offset bit of the bit index
    always_comb begin
        b_idx = {byte_off, 3'b000};
        h_idx = b_idx & ~IDX_W'(8);
        b_val = mem_data[b_idx +: 8];
        h_val = mem_data[h_idx +: 16];
        ext   = (ld_size == LD_B) ? {{(DATA_W-8){ld_signed & b_val[7]}}, b_val}
              : (ld_size == LD_H) ? {{(DATA_W-16){ld_signed & h_val[15]}}, h_val}
              : mem_data;
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: selects and registers register-file write data with stall/flush, retire count and illegal-select flag
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [PC_W-1:0]              pc,
    input  logic [DATA_W-1:0]            alu_res,
    input  logic [DATA_W-1:0]            mem_data,
    input  logic [REG_AW-1:0]            wr_reg,
    input  logic                         wr_en,
    input  logic [1:0]                   wb_sel,
    input  logic [1:0]                   ld_size,
    input  logic                         ld_signed,
    input  logic [$clog2(DATA_W/8)-1:0]  byte_off,
    output logic                         out_valid,
    output logic [PC_W-1:0]              pc_out,
    output logic [DATA_W-1:0]            wr_data,
    output logic [REG_AW-1:0]            wr_reg_out,
    output logic                         wr_en_out,
    output logic [CNT_W-1:0]             retired,
    output logic                         sel_err
);
    logic [DATA_W-1:0] ld_data, sel_data, data_q, data_d;
    logic [PC_W-1:0]   link_pc, pc_q, pc_d;
    logic [REG_AW-1:0] reg_q, reg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, bad;
    logic              valid_q, valid_d, wen_q, wen_d, err_q, err_d;

    load_extend #(.DATA_W(DATA_W)) u_ext (
        .mem_data (mem_data),
        .ld_size  (ld_size),
        .ld_signed(ld_signed),
        .byte_off (byte_off),
        .ext      (ld_data)
    );

    // Next state: flush beats stall beats accept; data regs only load on accept
    always_comb begin
        accept   = in_valid & ~stall & ~flush;
        bad      = wb_sel == WB_BAD;
        link_pc  = pc + PC_W'(LINK_INC);
        sel_data = (wb_sel == WB_ALU)  ? alu_res
                 : (wb_sel == WB_MEM)  ? ld_data
                 : (wb_sel == WB_LINK) ? DATA_W'(link_pc)
                 : '0;
        valid_d  = flush ? 1'b0 : stall ? valid_q : in_valid;
        pc_d     = accept ? pc : pc_q;
        data_d   = accept ? sel_data : data_q;
        reg_d    = accept ? wr_reg : reg_q;
        wen_d    = accept ? (wr_en & ~bad) : wen_q;
        cnt_d    = cnt_q + CNT_W'(accept);
        err_d    = err_q | (accept & bad);
    end

    // Pipeline register, retire counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
            reg_q   <= '0;
            wen_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            reg_q   <= reg_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign out_valid  = valid_q;
    assign pc_out     = pc_q;
    assign wr_data    = data_q;
    assign wr_reg_out = reg_q;
    assign wr_en_out  = valid_q & wen_q;
    assign retired    = cnt_q;
    assign sel_err    = err_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scoreboard bench for writeback_stage
module tb_writeback_stage;
    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [15:0] pc = '0;
    logic [31:0] alu_res = '0, mem_data = '0;
    logic [2:0]  wr_reg = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wb_sel = '0, ld_size = '0;
    logic        ld_signed = 1'b0;
    logic [1:0]  byte_off = '0;
    logic        out_valid, wr_en_out, sel_err;
    logic [15:0] pc_out;
    logic [31:0] wr_data;
    logic [2:0]  wr_reg_out;
    logic [3:0]  retired;

    typedef struct {
        logic        v;
        logic        we;
        logic [31:0] d;
        logic [2:0]  r;
        logic [15:0] p;
        logic [3:0]  ret;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   npass = 0, ntot = 0, exp_ret = 0;
    logic exp_err = 1'b0;

    writeback_stage #(.DATA_W(32), .PC_W(16), .REG_AW(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .pc(pc), .alu_res(alu_res), .mem_data(mem_data), .wr_reg(wr_reg), .wr_en(wr_en),
        .wb_sel(wb_sel), .ld_size(ld_size), .ld_signed(ld_signed), .byte_off(byte_off),
        .out_valid(out_valid), .pc_out(pc_out), .wr_data(wr_data), .wr_reg_out(wr_reg_out),
        .wr_en_out(wr_en_out), .retired(retired), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        ntot++;
        assert (got === want) npass++;
        else $error("FAIL %s got=%h want=%h", tag, got, want);
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        in_valid = 1'b1;
        alu_res = $urandom;
        pc = 16'($urandom);
        wr_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        exp_ret = 0;
        exp_err = 1'b0;
        last = '{v: 1'b0, we: 1'b0, d: '0, r: '0, p: '0, ret: '0, err: 1'b0};
        q.delete();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_wen", 32'(wr_en_out), 0);
        check("rst_err", 32'(sel_err), 0);
        check("rst_ret", 32'(retired), 0);
        check("rst_pc", 32'(pc_out), 0);
        check("rst_data", wr_data, 0);
        check("rst_reg", 32'(wr_reg_out), 0);
    endtask

    task automatic step(input string tag, input logic iv, input logic st, input logic fl,
                        input logic [1:0] sel, input logic [31:0] expd);
        exp_t e, got;
        in_valid = iv;
        stall = st;
        flush = fl;
        wb_sel = sel;
        e = last;
        if (fl) begin
            e.v = 1'b0;
            e.we = 1'b0;
        end else if (!st) begin
            e.v = iv;
            e.we = 1'b0;
            if (iv) begin
                e.we = wr_en && sel != 2'd3;
                e.d = expd;
                e.r = wr_reg;
                e.p = pc;
                exp_ret++;
                if (sel == 2'd3) exp_err = 1'b1;
            end
        end
        e.ret = 4'(exp_ret);
        e.err = exp_err;
        q.push_back(e);
        last = e;
        @(posedge clk);
        #1;
        got = q.pop_front();
        check({tag, "_valid"}, 32'(out_valid), 32'(got.v));
        check({tag, "_wen"}, 32'(wr_en_out), 32'(got.we));
        check({tag, "_ret"}, 32'(retired), 32'(got.ret));
        check({tag, "_err"}, 32'(sel_err), 32'(got.err));
        if (got.v) begin
            check({tag, "_data"}, wr_data, got.d);
            check({tag, "_reg"}, 32'(wr_reg_out), 32'(got.r));
            check({tag, "_pc"}, 32'(pc_out), 32'(got.p));
        end
    endtask

    initial begin
        reset_cycle();
        pc = 16'h0100; alu_res = 32'h12345678; wr_reg = 3'd5; wr_en = 1'b1;
        step("alu", 1, 0, 0, 2'd0, 32'h12345678);
        mem_data = 32'h80FF7F01; wr_reg = 3'd2;
        ld_size = 2'd0; byte_off = 2'd2; ld_signed = 1'b1;
        step("lb_off2_s", 1, 0, 0, 2'd1, 32'hFFFFFFFF);
        byte_off = 2'd0; ld_signed = 1'b0;
        step("lb_off0_u", 1, 0, 0, 2'd1, 32'h00000001);
        byte_off = 2'd3; ld_signed = 1'b1;
        step("lb_off3_s", 1, 0, 0, 2'd1, 32'hFFFFFF80);
        ld_size = 2'd1; byte_off = 2'd3; ld_signed = 1'b1;
        step("lh_off3_s", 1, 0, 0, 2'd1, 32'hFFFF80FF);
        byte_off = 2'd0; ld_signed = 1'b0;
        step("lh_off0_u", 1, 0, 0, 2'd1, 32'h00007F01);
        byte_off = 2'd0; ld_signed = 1'b1;
        step("lh_off0_s", 1, 0, 0, 2'd1, 32'h00007F01);
        ld_size = 2'd3; ld_signed = 1'b1;
        step("lw", 1, 0, 0, 2'd1, 32'h80FF7F01);
        pc = 16'hFFFF; wr_reg = 3'd7;
        step("link_wrap", 1, 0, 0, 2'd2, 32'h00000001);
        pc = 16'h1234;
        step("link", 1, 0, 0, 2'd2, 32'h00001236);
        step("idle", 0, 0, 0, 2'd0, 32'h0);
        pc = 16'h0200; alu_res = 32'hA5A50001; wr_reg = 3'd3; wr_en = 1'b1;
        step("stall_a", 1, 0, 0, 2'd0, 32'hA5A50001);
        for (int i = 0; i < 3; i++) begin
            pc = 16'($urandom); alu_res = $urandom; wr_reg = 3'($urandom);
            step("stall_hold", 1, 1, 0, 2'd0, 32'h0);
        end
        step("flush", 1, 1, 1, 2'd0, 32'h0);
        step("flush_stall", 0, 1, 0, 2'd0, 32'h0);
        pc = 16'h0300; alu_res = 32'hCAFEF00D; wr_reg = 3'd1; wr_en = 1'b0;
        step("no_wen", 1, 0, 0, 2'd0, 32'hCAFEF00D);
        wr_en = 1'b1; alu_res = 32'hDEADBEEF;
        step("bad_sel", 1, 0, 0, 2'd3, 32'h0);
        alu_res = 32'h00000042;
        step("after_bad", 1, 0, 0, 2'd0, 32'h00000042);
        for (int i = 0; i < 16; i++) begin
            alu_res = 32'(i); pc = 16'(i);
            step("cnt_wrap", 1, 0, 0, 2'd0, 32'(i));
        end
        step("in_flight", 1, 0, 0, 2'd0, 32'(15));
        reset_cycle();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
